// File: rtl/ring_count_capture.sv
// Ring-oscillator edge counter: synchronises ring_in, counts edges over a gated window, holds the result under valid/ack.
// Optional build macro RING_COUNT_BOTH_EDGES_EN counts falling as well as rising synchronised edges.
module ring_count_capture #(
  parameter int COUNT_W     = 32,
  parameter int WINDOW_W    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                ring_in,
  input  logic                start,
  input  logic [WINDOW_W-1:0] window_cycles,
  input  logic                count_ack,
  output logic                ring_en,
  output logic                busy,
  output logic [COUNT_W-1:0]  count_out,
  output logic                count_valid,
  output logic                overflow
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, HOLD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   sync_last;
  logic                   ring_edge;
  logic [WINDOW_W-1:0]    window_lat;
  logic [WINDOW_W-1:0]    timer;
  logic [ARM_W-1:0]       arm_cnt;
  logic [COUNT_W-1:0]     count;
  logic [COUNT_W:0]       count_inc;
  logic [COUNT_W-1:0]     next_count;
  logic                   next_ovf;

  // MSB of the result flags an increment attempted while already saturated.
  function automatic logic [COUNT_W:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (&v) return {1'b1, v};
    else    return {1'b0, v + 1'b1};
  endfunction

  assign sync_last = sync[SYNC_STAGES-1];

`ifdef RING_COUNT_BOTH_EDGES_EN
  assign ring_edge = sync_last ^ prev;
`else
  assign ring_edge = sync_last & ~prev;
`endif

  always_comb begin
    count_inc  = sat_inc(count);
    next_count = count;
    next_ovf   = overflow;
    if (ring_edge) begin
      next_count = count_inc[COUNT_W-1:0];
      next_ovf   = overflow | count_inc[COUNT_W];
    end
  end

  // ---- synchroniser and edge-detect stage ----
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ring_in};
      prev <= sync_last;
    end
  end

  // ---- measurement control stage ----
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state       <= IDLE;
      window_lat  <= '0;
      timer       <= '0;
      arm_cnt     <= '0;
      count       <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      ring_en     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            window_lat <= window_cycles;
            count      <= '0;
            overflow   <= 1'b0;
            arm_cnt    <= '0;
            ring_en    <= 1'b1;
            busy       <= 1'b1;
            state      <= ARM;
          end
        end
        ARM: begin
          // Stale synchroniser contents are flushed before any edge is counted.
          if (arm_cnt == ARM_W'(SYNC_STAGES)) begin
            if (window_lat == '0) begin
              count_out   <= '0;
              count_valid <= 1'b1;
              ring_en     <= 1'b0;
              busy        <= 1'b0;
              state       <= HOLD;
            end else begin
              timer <= window_lat;
              state <= COUNT;
            end
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        COUNT: begin
          count    <= next_count;
          overflow <= next_ovf;
          timer    <= timer - 1'b1;
          if (timer == WINDOW_W'(1)) begin
            count_out   <= next_count;
            count_valid <= 1'b1;
            ring_en     <= 1'b0;
            busy        <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (count_ack) begin
            count_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_count_capture.sv
// Bench for ring_count_capture: a default-width instance and a 4-bit-counter instance share the same stimulus.
module tb_ring_count_capture;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ring_in;
  logic        start;
  logic        count_ack;
  logic [31:0] window_cycles;

  logic        ring_en, busy, count_valid, overflow;
  logic [31:0] count_out;
  logic        ring_en4, busy4, count_valid4, overflow4;
  logic [3:0]  count_out4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ring_mode = 2;
  logic hist [0:8191];

  ring_count_capture dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .ring_in(ring_in), .start(start),
    .window_cycles(window_cycles), .count_ack(count_ack), .ring_en(ring_en),
    .busy(busy), .count_out(count_out), .count_valid(count_valid), .overflow(overflow)
  );

  ring_count_capture #(.COUNT_W(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .ring_in(ring_in), .start(start),
    .window_cycles(window_cycles), .count_ack(count_ack), .ring_en(ring_en4),
    .busy(busy4), .count_out(count_out4), .count_valid(count_valid4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  // Ring value seen by the synchroniser at each rising edge (reset forces the flops to 0).
  always @(posedge clk) begin
    hist[cyc % 8192] <= rst_n ? ring_in : 1'b0;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    case (ring_mode)
      0:       ring_in = 1'b0;
      1:       ring_in = 1'b1;
      2:       ring_in = ~ring_in;
      default: ring_in = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Edges are counted in the W cycles that follow the start edge plus the flush period.
  function automatic int model_count(input int t, input int w);
    int n = 0;
    for (int j = t + S + 2; j <= t + S + 1 + w; j++) begin
      logic a, b;
      a = hist[(j - S) % 8192];
      b = hist[(j - S - 1) % 8192];
`ifdef RING_COUNT_BOTH_EDGES_EN
      if (a != b) n++;
`else
      if (a && !b) n++;
`endif
    end
    return n;
  endfunction

  function automatic int sat4(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic run(input int w, input bit poke, output int t, output int lat, output int en_cycles);
    int k;
    @(negedge clk);
    window_cycles = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = cyc - 1;
    window_cycles = $urandom;
    k = 1;
    en_cycles = ring_en ? 1 : 0;
    while (!count_valid && k < 2000) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (ring_en) en_cycles++;
      start = poke && (k == 2 || k == w / 2 + 4);
    end
    start = 1'b0;
    lat = k;
    if (k >= 2000) check("valid_timeout", k, w + S + 2);
  endtask

  task automatic do_ack(input int delay);
    repeat (delay) @(negedge clk);
    count_ack = 1'b1;
    @(negedge clk);
    count_ack = 1'b0;
    check("ack_valid_drop", count_valid, 0);
    check("ack_valid_drop4", count_valid4, 0);
  endtask

  typedef struct {
    int mode;
    int w;
    int rise;
    int both;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int t, lat, en, exp, n, stable_bad, en_seen;

    tbl[0] = '{2, 64, 32, 64};
    tbl[1] = '{1, 100, 0, 0};
    tbl[2] = '{2, 0, 0, 0};
    tbl[3] = '{2, 8, 4, 8};
    tbl[4] = '{0, 20, 0, 0};
    tbl[5] = '{2, 30, 15, 30};

    rst_n = 1'b0; ring_in = 1'b0; start = 1'b0; count_ack = 1'b0; window_cycles = '0;

    // Reset with a live ring, then idle with no start.
    repeat (3) @(negedge clk);
    check("rst_ring_en", ring_en, 0);
    check("rst_busy", busy, 0);
    check("rst_count_out", count_out, 0);
    check("rst_valid", count_valid, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    en_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ring_en || busy || count_valid) en_seen++;
    end
    check("idle_no_activity", en_seen, 0);

    // Table-driven measurements.
    for (int i = 0; i < 6; i++) begin
      ring_mode = tbl[i].mode;
      repeat (4) @(negedge clk);
`ifdef RING_COUNT_BOTH_EDGES_EN
      exp = tbl[i].both;
`else
      exp = tbl[i].rise;
`endif
      run(tbl[i].w, i == 0, t, lat, en);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].w + S + 2);
      check($sformatf("tbl%0d_ring_en_cycles", i), en, tbl[i].w + S + 1);
      check($sformatf("tbl%0d_count", i), count_out, exp);
      check($sformatf("tbl%0d_overflow", i), overflow, 0);
      check($sformatf("tbl%0d_count4", i), count_out4, sat4(exp));
      check($sformatf("tbl%0d_overflow4", i), overflow4, exp > 15);
      check($sformatf("tbl%0d_busy", i), busy, 0);
      check($sformatf("tbl%0d_ring_en_off", i), ring_en, 0);
      do_ack(i % 3);
    end

    // Handshake: result held while unacknowledged, start ignored in HOLD.
    ring_mode = 2;
    repeat (4) @(negedge clk);
    run(10, 1'b0, t, lat, en);
`ifdef RING_COUNT_BOTH_EDGES_EN
    exp = 10;
`else
    exp = 5;
`endif
    check("hs_count", count_out, exp);
    stable_bad = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      @(negedge clk);
      if (!count_valid || count_out != exp || busy || ring_en) stable_bad++;
    end
    start = 1'b0;
    check("hs_hold_stable", stable_bad, 0);
    count_ack = 1'b1;
    start = 1'b1;
    @(negedge clk);
    count_ack = 1'b0;
    start = 1'b0;
    check("hs_ack_start_valid", count_valid, 0);
    check("hs_ack_start_busy", busy, 0);
    en_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ring_en || busy) en_seen++;
    end
    check("hs_no_new_run", en_seen, 0);
    check("hs_count_retained", count_out, exp);

    // Reset halfway through a window=64 measurement.
    @(negedge clk);
    window_cycles = 64;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (35) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ring_en", ring_en, 0);
    check("midrst_valid", count_valid, 0);
    check("midrst_count_out", count_out, 0);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    en_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ring_en || count_valid) en_seen++;
    end
    check("midrst_stays_idle", en_seen, 0);

    // Randomised ring against the edge-counting model.
    ring_mode = 3;
    for (int i = 0; i < 20; i++) begin
      int w;
      w = $urandom_range(0, 40);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(w, i[0], t, lat, en);
      n = model_count(t, w);
      check($sformatf("rnd%0d_latency", i), lat, w + S + 2);
      check($sformatf("rnd%0d_count", i), count_out, n);
      check($sformatf("rnd%0d_overflow", i), overflow, 0);
      check($sformatf("rnd%0d_count4", i), count_out4, sat4(n));
      check($sformatf("rnd%0d_overflow4", i), overflow4, n > 15);
      do_ack($urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
